// File: rtl/uart_rx_path.sv
// Receive path of the UART: synchronizer, optional glitch filter, 16x oversampling receiver, receive FIFO.
// Define UART_RX_NOISE_FILTER_EN to add the 3-sample majority filter in front of the receiver.
module uart_rx_path #(
    parameter int Depth  = 16,
    parameter int DepthW = $clog2(Depth) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              rx_enable_i,
    input  logic [15:0]       nco_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              fifo_clr_i,
    input  logic              rready_i,
    output logic              rvalid_o,
    output logic [7:0]        rdata_o,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              idle_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overflow_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic sync1_q, sync2_q;
    logic rx_in;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef UART_RX_NOISE_FILTER_EN
    logic filt1_q, filt2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt1_q <= 1'b1;
            filt2_q <= 1'b1;
        end else begin
            filt1_q <= sync2_q;
            filt2_q <= filt1_q;
        end
    end

    // Two of three consecutive samples must agree, so a single-cycle glitch never reaches the receiver.
    assign rx_in = (sync2_q & filt1_q) | (sync2_q & filt2_q) | (filt1_q & filt2_q);
`else
    assign rx_in = sync2_q;
`endif

    logic [16:0] acc_q, acc_d;
    logic        tick;

    assign acc_d = rx_enable_i ? ({1'b0, acc_q[15:0]} + {1'b0, nco_i}) : acc_q;
    assign tick  = acc_q[16];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    state_e     state_q, state_d;
    logic [3:0] sub_q, sub_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic       perr_acc_q, perr_acc_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       parity_err_q, parity_err_d;

    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        bit_d        = bit_q;
        data_d       = data_q;
        perr_acc_d   = perr_acc_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (!rx_enable_i) begin
            state_d = IDLE;
            sub_d   = '0;
            bit_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_in) begin
                        state_d    = START;
                        sub_d      = '0;
                        bit_d      = '0;
                        perr_acc_d = 1'b0;
                    end
                end
                START: begin
                    // Mid-start check rejects short low pulses as false starts.
                    if (sub_q == 4'd7) begin
                        sub_d   = '0;
                        state_d = rx_in ? IDLE : DATA;
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
                DATA: begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        data_d = {rx_in, data_q[7:1]};
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = parity_en_i ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        perr_acc_d = (^data_q) ^ parity_odd_i ^ rx_in;
                        state_d    = STOP;
                    end
                end
                STOP: begin
                    sub_d = sub_q + 4'd1;
                    if (sub_q == 4'd15) begin
                        state_d      = IDLE;
                        rx_valid_d   = 1'b1;
                        frame_err_d  = ~rx_in;
                        parity_err_d = perr_acc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            sub_q        <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            perr_acc_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sub_q        <= sub_d;
            bit_q        <= bit_d;
            data_q       <= data_d;
            perr_acc_q   <= perr_acc_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign idle_o       = (state_q == IDLE);
    assign rx_valid_o   = rx_valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;

    logic [7:0]        mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [DepthW-1:0] count_q;
    logic              empty, full, pop, wr_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == DepthFull);
    assign pop   = rready_i & ~empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted then.
    assign wr_en = rx_valid_q & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || fifo_clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= ptr_inc(wptr_q);
            if (pop)   rptr_q <= ptr_inc(rptr_q);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + DepthW'(1);
                2'b01:   count_q <= count_q - DepthW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !fifo_clr_i && wr_en) mem_q[wptr_q] <= data_q;
    end

    assign rvalid_o   = ~empty;
    assign full_o     = full;
    assign depth_o    = count_q;
    assign rdata_o    = empty ? 8'h00 : mem_q[rptr_q];
    assign overflow_o = rx_valid_q & full & ~pop;

endmodule

// File: tb/tb_uart_rx_path.sv
// Self-checking bench for uart_rx_path: serial frames are synthesized at bit level, a frame scoreboard
// and a queue model of the receive FIFO are checked by an independent monitor on every falling edge.
module tb_uart_rx_path;

    localparam int Depth  = 16;
    localparam int DepthW = $clog2(Depth) + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              rx_i;
    logic              rx_enable_i;
    logic [15:0]       nco_i;
    logic              parity_en_i;
    logic              parity_odd_i;
    logic              fifo_clr_i;
    logic              rready_i;
    logic              rvalid_o;
    logic [7:0]        rdata_o;
    logic [DepthW-1:0] depth_o;
    logic              full_o;
    logic              idle_o;
    logic              rx_valid_o;
    logic              frame_err_o;
    logic              parity_err_o;
    logic              overflow_o;

    int         checks = 0;
    int         errors = 0;
    int         bitClks = 32;
    int         ovCount = 0;
    bit         monitorOn = 1'b0;
    bit         popRandom = 1'b0;
    bit         popReq = 1'b0;
    frame_t     frameQ[$];
    logic [7:0] modelQ[$];

    uart_rx_path #(.Depth(Depth)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .rx_enable_i  (rx_enable_i),
        .nco_i        (nco_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .fifo_clr_i   (fifo_clr_i),
        .rready_i     (rready_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .depth_o      (depth_o),
        .full_o       (full_o),
        .idle_o       (idle_o),
        .rx_valid_o   (rx_valid_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single driver for rready_i: random pops or explicit requests from the main sequence.
    initial begin
        rready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            rready_i = popRandom ? ($urandom_range(0, 63) == 0) : popReq;
        end
    end

    // Monitor: the FIFO model is what a byte queue of capacity Depth holds, delayed by one cycle.
    int     monDepth;
    bit     monPop;
    frame_t monE;
    always @(negedge clk_i) begin
        if (monitorOn) begin
            if (!rst_ni) begin
                modelQ.delete();
            end else begin
                monDepth = modelQ.size();
                checkOutput("depth", 32'(depth_o), 32'(monDepth));
                checkOutput("rvalid", 32'(rvalid_o), 32'(monDepth != 0));
                checkOutput("full", 32'(full_o), 32'(monDepth == Depth));
                if (monDepth != 0) checkOutput("rdata", 32'(rdata_o), 32'(modelQ[0]));
                else               checkOutput("rdataEmpty", 32'(rdata_o), 32'h0);
                monPop = rready_i && (monDepth != 0);
                checkOutput("overflow", 32'(overflow_o),
                            32'(rx_valid_o && monDepth == Depth && !monPop));
                if (overflow_o) ovCount++;
                if (fifo_clr_i) begin
                    modelQ.delete();
                end else if (monPop) begin
                    void'(modelQ.pop_front());
                end
                if (rx_valid_o) begin
                    if (frameQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedByte: got rx_valid_o=1, expected no byte at %0t", $time);
                    end else begin
                        monE = frameQ.pop_front();
                        checkOutput("frameErr", 32'(frame_err_o), 32'(monE.ferr));
                        checkOutput("parityErr", 32'(parity_err_o), 32'(monE.perr));
                        if (!fifo_clr_i && (monDepth < Depth || monPop)) modelQ.push_back(monE.data);
                    end
                end else begin
                    checkOutput("errNoValid", 32'({frame_err_o, parity_err_o}), 32'h0);
                end
            end
        end
    end

    task automatic driveLevel(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic setBaud(input logic [15:0] nco);
        nco_i   = nco;
        bitClks = (16 * 65536) / int'(nco);
    endtask

    // Sends one frame and records what a correct receiver must report for it.
    task automatic applyStimulus(input logic [7:0] data, input bit parEn, input bit parOdd,
                                 input bit parBit, input bit stopOk);
        frame_t e;
        bit     goodPar;
        parity_en_i  = parEn;
        parity_odd_i = parOdd;
        goodPar = parOdd ? ~(^data) : (^data);
        e.data = data;
        e.ferr = !stopOk;
        e.perr = parEn && (parBit != goodPar);
        frameQ.push_back(e);
        driveLevel(1'b0, bitClks);
        for (int i = 0; i < 8; i++) driveLevel(data[i], bitClks);
        if (parEn) driveLevel(parBit, bitClks);
        if (stopOk) begin
            driveLevel(1'b1, bitClks);
        end else begin
            driveLevel(1'b0, (bitClks * 3) / 4);
            driveLevel(1'b1, bitClks / 4);
        end
        driveLevel(1'b1, bitClks / 2 + int'($urandom_range(0, 16)));
    endtask

    task automatic sendPartial(input logic [7:0] data, input int nBits);
        driveLevel(1'b0, bitClks);
        for (int i = 0; i < nBits; i++) driveLevel(data[i], bitClks);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (frameQ.size() != 0 && n < 4000) begin
            @(posedge clk_i);
            n++;
        end
        checks++;
        if (frameQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drainTimeout: got %0d frames pending, expected 0", frameQ.size());
            frameQ.delete();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic doPop(input bit withClear);
        popReq     = 1'b1;
        fifo_clr_i = withClear;
        @(posedge clk_i);
        #1;
        popReq     = 1'b0;
        fifo_clr_i = 1'b0;
    endtask

    initial begin
        logic [7:0] firstByte;
        int         ovBefore;
        rst_ni       = 1'b0;
        rx_i         = 1'b1;
        rx_enable_i  = 1'b1;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        fifo_clr_i   = 1'b0;
        setBaud(16'h8000);
        repeat (4) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkOutput("resetIdle", 32'(idle_o), 32'h1);
        checkOutput("resetDepth", 32'(depth_o), 32'h0);
        checkOutput("resetRvalid", 32'(rvalid_o), 32'h0);
        checkOutput("resetRdata", 32'(rdata_o), 32'h0);
        checkOutput("resetPulses", 32'({rx_valid_o, frame_err_o, parity_err_o, overflow_o}), 32'h0);
        monitorOn = 1'b1;

        $display("[TB] basic byte, framing error, parity");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        waitDrain();
        checkOutput("a5Depth", 32'(depth_o), 32'h1);
        checkOutput("a5Data", 32'(rdata_o), 32'hA5);
        doPop(1'b0);
        checkOutput("a5PopRvalid", 32'(rvalid_o), 32'h0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain();
        checkOutput("ferrStored", 32'(rdata_o), 32'h00);
        checkOutput("ferrDepth", 32'(depth_o), 32'h1);
        checkOutput("ferrIdle", 32'(idle_o), 32'h1);
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
        waitDrain();
        checkOutput("parDepth", 32'(depth_o), 32'h3);

        $display("[TB] fill past capacity");
        doPop(1'b1);
        checkOutput("clrDepth", 32'(depth_o), 32'h0);
        ovBefore = ovCount;
        firstByte = 8'($urandom);
        applyStimulus(firstByte, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < Depth; i++) applyStimulus(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        waitDrain();
        checkOutput("fullFlag", 32'(full_o), 32'h1);
        checkOutput("fullDepth", 32'(depth_o), 32'(Depth));
        checkOutput("overflowOnce", 32'(ovCount - ovBefore), 32'h1);
        checkOutput("fullHead", 32'(rdata_o), 32'(firstByte));

        $display("[TB] clear with pop, short low pulse");
        doPop(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        waitDrain();
        checkOutput("fourQueued", 32'(depth_o), 32'h4);
        doPop(1'b1);
        checkOutput("clrPopDepth", 32'(depth_o), 32'h0);
        driveLevel(1'b0, 3);
        driveLevel(1'b1, 100);
        checkOutput("pulseIdle", 32'(idle_o), 32'h1);
        checkOutput("pulseDepth", 32'(depth_o), 32'h0);

        $display("[TB] randomized frames");
        popRandom = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bit pe, po, pb;
            setBaud(($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h4000);
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            applyStimulus(8'($urandom), pe, po, pb, $urandom_range(0, 6) != 0);
        end
        waitDrain();
        popRandom = 1'b0;
        setBaud(16'h8000);
        parity_en_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        $display("[TB] disable mid-frame");
        sendPartial(8'h5A, 3);
        checkOutput("busyBeforeDisable", 32'(idle_o), 32'h0);
        rx_enable_i = 1'b0;
        rx_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("disableIdle", 32'(idle_o), 32'h1);
        driveLevel(1'b1, 10);
        rx_enable_i = 1'b1;
        driveLevel(1'b1, 400);

        $display("[TB] reset mid-byte");
        doPop(1'b1);
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        waitDrain();
        checkOutput("preResetDepth", 32'(depth_o), 32'h2);
        sendPartial(8'h0F, 4);
        checkOutput("busyBeforeReset", 32'(idle_o), 32'h0);
        rst_ni = 1'b0;
        rx_i   = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkOutput("midResetIdle", 32'(idle_o), 32'h1);
        checkOutput("midResetDepth", 32'(depth_o), 32'h0);
        checkOutput("midResetRvalid", 32'(rvalid_o), 32'h0);
        driveLevel(1'b1, 400);

        $display("[TB] single-clock glitch");
        driveLevel(1'b0, 1);
        rx_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
`ifdef UART_RX_NOISE_FILTER_EN
            checkOutput("glitchIdle", 32'(idle_o), 32'h1);
`endif
        end
        @(posedge clk_i);
        #1;
        driveLevel(1'b1, 60);
        checkOutput("glitchNoByte", 32'(depth_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_rx_path.md
Name: uart_rx_path

Overview:
- Receive half of the UART.
- Chain: rx pin → 2-flop synchronizer → optional 3-sample majority filter → 16x-oversampling 8-bit receiver (optional parity) → synchronous receive FIFO.
- Includes its own 16-bit NCO for the 16x baud tick.
- Sits between the rx pad and the register block; the register block drives the config inputs and pops the FIFO.

Parameters:
- Depth, 16, FIFO entries (2..255).
- DepthW, $clog2(Depth)+1, derived width of depth_o.

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, synchronous, active-low.
- rx_i  in  1  asynchronous serial input, idle high.
- rx_enable_i  in  1  receiver and NCO enable.
- nco_i  in  16  NCO increment; tick_x16 rate = f_clk*nco_i/65536.
- parity_en_i  in  1  9th (parity) bit present.
- parity_odd_i  in  1  odd parity when 1, even when 0.
- fifo_clr_i  in  1  single-cycle FIFO flush.
- rready_i  in  1  FIFO pop.
- rvalid_o  out  1  FIFO non-empty.
- rdata_o  out  8  FIFO head byte.
- depth_o  out  DepthW  entries held.
- full_o  out  1  depth_o == Depth.
- idle_o  out  1  receiver in IDLE.
- rx_valid_o  out  1  one-cycle pulse when a byte is complete.
- frame_err_o  out  1  pulse with rx_valid_o when stop bit sampled 0.
- parity_err_o  out  1  pulse with rx_valid_o on parity mismatch.
- overflow_o  out  1  pulse when a completed byte is dropped because the FIFO is full.

Behaviour:
- Reset (rst_ni low at clk_i edge):
  - Synchronizer and filter flops = 1; NCO accumulator = 0.
  - Receiver in IDLE; all pulse outputs 0; idle_o = 1.
  - FIFO empty: depth_o = 0, rvalid_o = 0, rdata_o = 0.
  - Reset mid-frame abandons the frame; no rx_valid_o pulse.
- Synchronizer: two flops, reset value 1; rx_sync lags rx_i by 2 cycles.
- NCO: 17-bit accumulator. When rx_enable_i is high, acc <= {0, acc[15:0]} + {0, nco_i}. tick_x16 = acc[16]. The accumulator holds when the receiver is disabled.
- Receiver states: IDLE, START, DATA, PARITY, STOP. All state changes occur only on tick_x16 cycles with rx_enable_i high. A 4-bit subcounter counts ticks within a bit.
  - IDLE: if rx_in == 0, go to START with sub = 0.
  - START: at sub == 7, sample. If rx_in is 1 (false start), return to IDLE silently; else go to DATA with sub = 0.
  - DATA: sample at every sub == 15, LSB first. After 8 bits, go to PARITY if parity_en_i, else STOP.
  - PARITY: sample at sub == 15. parity_err = (^data) ^ parity_odd_i ^ sampled_bit.
  - STOP: sample at sub == 15, then return to IDLE. Next cycle: rx_valid_o = 1; frame_err_o = !stop_bit; parity_err_o as computed (0 if parity disabled).
- Disabling rx_enable_i mid-frame returns the receiver to IDLE at the next clock.
- FIFO write = rx_valid_o. Bytes with a frame or parity error are still written.
- FIFO pop = rready_i & rvalid_o.
- Same-cycle write and pop with 0 < depth < Depth: depth unchanged, both take effect.
- Write when full: byte dropped, overflow_o = 1 that cycle. If a pop also occurs that cycle, the write is accepted.
- Pop when empty is ignored.
- fifo_clr_i has priority over write and pop in the same cycle: depth_o = 0 next cycle.
- rdata_o is registered-free: a direct read of the head entry. It is 0 when empty.
- depth_o, rvalid_o and full_o update one cycle after the write, pop or clear.

Optional Feature:
- Macro UART_RX_NOISE_FILTER_EN.
- Defined: two more flops after the synchronizer (reset 1). rx_in = majority(rx_sync, q1, q2), which suppresses 1-cycle glitches and adds 1 cycle of latency on edges.
- Undefined: rx_in = rx_sync directly; 1-cycle glitches can trigger a START, which then fails the mid-start check.

Test Plan:
- nco_i = 0x8000 (tick every 2 clocks, bit = 32 clocks), parity off, send 0xA5 with a valid stop bit → one rx_valid_o pulse, frame_err_o = 0, depth_o = 1, rdata_o = 0xA5; pop → rvalid_o = 0.
- Send 0x00 with stop bit 0 → rx_valid_o pulse with frame_err_o = 1; byte 0x00 stored; receiver returns to IDLE.
- parity_en_i = 1, parity_odd_i = 0: send 0x03 with parity 0 → parity_err_o = 0. Send 0x03 with parity 1 → parity_err_o = 1, byte still stored.
- Send Depth+1 bytes without popping → full_o = 1, depth_o = Depth; overflow_o pulses once on the last byte; the first byte remains at the head.
- 4 bytes queued, assert fifo_clr_i together with rready_i → depth_o = 0 next cycle; a 3-clock low pulse on rx_i while idle → no byte received.
- Assert rst_ni low mid-byte → idle_o = 1, depth_o = 0, no rx_valid_o pulse. With UART_RX_NOISE_FILTER_EN defined, a 1-clock low glitch leaves idle_o = 1 throughout.
